// File: rtl/mem_burst_responder.sv
// Main-memory burst responder behind the L1 cache: fixed-latency block refills
// (read bursts) and dirty-block writebacks (write bursts) over a word array.
module mem_burst_responder #(
   parameter int ADDR_W = 26,
   parameter int WORDS  = 16,
   parameter int DEPTH  = 1024,
   parameter int LAT    = 20
) (
   input  logic              clock_me,
   input  logic              reset_0,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_blk,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [31:0]       rd_data,
   output logic              rd_last,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [31:0]       wr_data,
   output logic              done,
   output logic              err
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BEAT_W = $clog2(WORDS);
   localparam int BLK_W  = IDX_W - BEAT_W;
   localparam int CNT_W  = (LAT > 1) ? $clog2(LAT + 1) : 1;
   localparam logic [ADDR_W-1:0] NBLK      = ADDR_W'(DEPTH / WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RD,
      S_WR
   } state_t;

   state_t             state_q, state_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic               write_q, write_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic               mem_we;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        mem [DEPTH];

   // Only the low block bits address the array; out-of-range blocks alias but
   // are guarded by err_q on both read and write.
   assign idx = {blk_q, beat_q};

   always_ff @(posedge clock_me or posedge reset_0) begin
      if (reset_0) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         cnt_q   <= '0;
         blk_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         write_q <= write_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clock_me) begin
      if (mem_we) begin
         mem[idx] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      write_d = write_q;
      err_d   = err_q;
      done_d  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               blk_d   = req_blk[BLK_W-1:0];
               err_d   = (req_blk >= NBLK);
               beat_d  = '0;
               if (LAT == 0) begin
                  state_d = req_write ? S_WR : S_RD;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(LAT);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = write_q ? S_WR : S_RD;
            end
         end
         S_RD: begin
            if (rd_ready) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         S_WR: begin
            if (wr_valid) begin
               mem_we = !err_q;
               if (beat_q == LAST_BEAT) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign rd_valid  = (state_q == S_RD);
   assign wr_ready  = (state_q == S_WR);
   assign rd_last   = (state_q == S_RD) && (beat_q == LAST_BEAT);
   assign rd_data   = ((state_q == S_RD) && !err_q) ? mem[idx] : 32'h0;
   assign done      = done_q;
   assign err       = err_q && (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: a LAT=20 instance for the main flows
// and a LAT=0 instance for the zero-latency handshake.
module tb_mem_burst_responder;

   localparam int ADDR_W = 26;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_write, rd_ready, wr_valid;
   logic [ADDR_W-1:0] req_blk;
   logic [31:0]       wr_data, rd_data;
   logic              req_ready, rd_valid, rd_last, wr_ready, done, err;

   logic              req_valid_z, req_write_z, rd_ready_z, wr_valid_z;
   logic [ADDR_W-1:0] req_blk_z;
   logic [31:0]       wr_data_z, rd_data_z;
   logic              req_ready_z, rd_valid_z, rd_last_z, wr_ready_z, done_z, err_z;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_burst_responder #(.ADDR_W(ADDR_W), .WORDS(16), .DEPTH(1024), .LAT(20)) dut (
      .clock_me(clk), .reset_0(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_blk(req_blk),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .done(done), .err(err)
   );

   mem_burst_responder #(.ADDR_W(ADDR_W), .WORDS(16), .DEPTH(1024), .LAT(0)) dut_z (
      .clock_me(clk), .reset_0(rst),
      .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z), .req_blk(req_blk_z),
      .rd_valid(rd_valid_z), .rd_ready(rd_ready_z), .rd_data(rd_data_z), .rd_last(rd_last_z),
      .wr_valid(wr_valid_z), .wr_ready(wr_ready_z), .wr_data(wr_data_z),
      .done(done_z), .err(err_z)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic w, input int blk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = w;
      req_blk   = ADDR_W'(blk);
      tick();
      req_valid = 1'b0;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
   endtask

   task automatic wr_burst(input int blk, input logic [31:0] lo, input logic [31:0] step,
                           input logic e, input int nbeats);
      int k;
      do_req(1'b1, blk);
      chk("wr_err_wait", 32'(err), 32'(e));
      k = 0;
      while (!wr_ready && k < 100) begin
         tick();
         k++;
      end
      chk("wr_latency", 32'(k), 32'd20);
      for (int i = 0; i < nbeats; i++) begin
         chk("wr_ready", 32'(wr_ready), 32'd1);
         chk("wr_err", 32'(err), 32'(e));
         wr_valid = 1'b1;
         wr_data  = lo + step * 32'(i);
         tick();
      end
      if (nbeats == 16) begin
         wr_valid = 1'b0;
         chk("wr_done", 32'(done), 32'd1);
         chk("wr_back_idle", 32'(req_ready), 32'd1);
         tick();
         chk("wr_done_once", 32'(done), 32'd0);
      end
   endtask

   task automatic rd_burst(input int blk, input logic [31:0] lo, input logic [31:0] step,
                           input int split, input logic [31:0] hi, input logic e,
                           input int s0, input int s1);
      int k, beat, cyc;
      logic stall;
      logic [31:0] ex;
      do_req(1'b0, blk);
      chk("rd_err_wait", 32'(err), 32'(e));
      k = 0;
      while (!rd_valid && k < 100) begin
         tick();
         k++;
      end
      chk("rd_latency", 32'(k), 32'd20);
      beat = 0;
      cyc  = 0;
      while (beat < 16 && cyc < 60) begin
         ex = (beat < split) ? lo + step * 32'(beat) : hi;
         chk("rd_valid", 32'(rd_valid), 32'd1);
         chk("rd_data", rd_data, ex);
         chk("rd_last", 32'(rd_last), 32'(beat == 15));
         chk("rd_err", 32'(err), 32'(e));
         stall    = (cyc >= s0) && (cyc < s1);
         rd_ready = !stall;
         tick();
         if (!stall) beat++;
         cyc++;
      end
      rd_ready = 1'b0;
      chk("rd_beats", 32'(beat), 32'd16);
      chk("rd_done", 32'(done), 32'd1);
      chk("rd_valid_end", 32'(rd_valid), 32'd0);
      chk("err_idle", 32'(err), 32'd0);
      tick();
      chk("rd_done_once", 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_blk = '0;
      rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
      req_valid_z = 1'b0; req_write_z = 1'b0; req_blk_z = '0;
      rd_ready_z = 1'b0; wr_valid_z = 1'b0; wr_data_z = '0;
      repeat (3) tick();
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      // main write/read, then backpressure on the same block
      wr_burst(3, 32'hA000_0000, 32'd1, 1'b0, 16);
      rd_burst(3, 32'hA000_0000, 32'd1, 16, 32'h0, 1'b0, 0, 0);
      rd_burst(3, 32'hA000_0000, 32'd1, 16, 32'h0, 1'b0, 4, 7);

      // out-of-range read, and an out-of-range write that must not touch blk 6
      wr_burst(6, 32'h6666_0000, 32'd1, 1'b0, 16);
      rd_burst(64, 32'h0, 32'd0, 16, 32'h0, 1'b1, 0, 0);
      wr_burst(70, 32'hDEAD_0000, 32'd1, 1'b1, 16);
      rd_burst(6, 32'h6666_0000, 32'd1, 16, 32'h0, 1'b0, 0, 0);

      // reset while beat 7 of a writeback is being presented
      wr_burst(5, 32'h1111_1111, 32'd0, 1'b0, 16);
      wr_burst(5, 32'hBEEF_0000, 32'd1, 1'b0, 7);
      wr_data = 32'hBEEF_0007;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      #1 rst = 1'b0;
      wr_valid = 1'b0;
      tick();
      chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
      rd_burst(5, 32'hBEEF_0000, 32'd1, 7, 32'h1111_1111, 1'b0, 0, 0);

      // zero-latency instance
      req_valid_z = 1'b1; req_write_z = 1'b1; req_blk_z = ADDR_W'(1);
      tick();
      req_valid_z = 1'b0;
      chk("z_wr_ready", 32'(wr_ready_z), 32'd1);
      for (int i = 0; i < 16; i++) begin
         wr_valid_z = 1'b1;
         wr_data_z  = 32'hC0DE_0000 + 32'(i);
         tick();
      end
      wr_valid_z = 1'b0;
      chk("z_wr_done", 32'(done_z), 32'd1);
      req_valid_z = 1'b1; req_write_z = 1'b0;
      tick();
      chk("z_rd_valid", 32'(rd_valid_z), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("z_req_held", 32'(req_ready_z), 32'd0);
         chk("z_rd_data", rd_data_z, 32'hC0DE_0000 + 32'(i));
         chk("z_rd_last", 32'(rd_last_z), 32'(i == 15));
         rd_ready_z = 1'b1;
         tick();
      end
      req_valid_z = 1'b0;
      rd_ready_z  = 1'b0;
      chk("z_rd_done", 32'(done_z), 32'd1);
      chk("z_idle", 32'(req_ready_z), 32'd1);
      tick();
      chk("z_rd_valid_end", 32'(rd_valid_z), 32'd0);
      chk("z_done_once", 32'(done_z), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
